// File: rtl/isa_cycle_sequencer_if.sv
// Command and ISA bus bundle for isa_cycle_sequencer.
// The master modport is the sequencer; slave is the register file / bus environment.
interface isa_cycle_sequencer_if;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 16;

    logic          start;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          ctrl_clear;
    logic [AW-1:0] isa_addr;
    logic [DW-1:0] isa_data_out;
    logic          isa_data_oe;
    logic [DW-1:0] isa_data_in;
    logic          isa_ior_n;
    logic          isa_iow_n;
    logic          isa_iochrdy;

    modport master (
        input  start, cmd_write, cmd_addr, cmd_wdata, isa_data_in, isa_iochrdy,
        output busy, done, timeout, rdata, rdata_valid, ctrl_clear,
               isa_addr, isa_data_out, isa_data_oe, isa_ior_n, isa_iow_n
    );

    modport slave (
        output start, cmd_write, cmd_addr, cmd_wdata, isa_data_in, isa_iochrdy,
        input  busy, done, timeout, rdata, rdata_valid, ctrl_clear,
               isa_addr, isa_data_out, isa_data_oe, isa_ior_n, isa_iow_n
    );
endinterface

// File: rtl/isa_cycle_sequencer.sv
// Single-command ISA I/O cycle engine: IDLE -> SETUP -> STROBE -> WAIT_RDY -> HOLD -> DONE.
// Define ISA_TIMEOUT_EN to bound WAIT_RDY at TIMEOUT_CYCLES clocks and report an aborted cycle.
module isa_cycle_sequencer #(
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned STROBE_CYCLES  = 16,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    isa_cycle_sequencer_if.master bus
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;

    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
        $error("SETUP_CYCLES must be in 1..255");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 255) begin : g_bad_strobe
        $error("STROBE_CYCLES must be in 1..255");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_RDY,
        ST_HOLD,
        ST_DONE
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             write_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             busy_q;
    logic             done_q;
    logic             ctrl_clear_q;
    logic             rdata_valid_q;
    logic [DW-1:0]    rdata_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    dout_q;
    logic             oe_q;
    logic             ior_n_q;
    logic             iow_n_q;
    logic             to_hit_c;
    logic             aborted_c;

    // IOCHRDY is asynchronous to clk; only sync2_q may be used by the FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.isa_iochrdy;
            sync2_q <= sync1_q;
        end
    end

`ifdef ISA_TIMEOUT_EN
    localparam int unsigned TO_W = 16;

    logic [TO_W-1:0] wait_cnt_q;
    logic            aborted_q;
    logic            timeout_q;

    assign to_hit_c  = (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign aborted_c = aborted_q;

    // WAIT_RDY residency counter; aborted_q remembers a timed-out cycle until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            aborted_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state_q == ST_WAIT_RDY) begin
                wait_cnt_q <= wait_cnt_q + TO_W'(1);
            end else begin
                wait_cnt_q <= '0;
            end
            if (state_q == ST_IDLE && bus.start) begin
                aborted_q <= 1'b0;
            end else if (state_q == ST_WAIT_RDY && !sync2_q && to_hit_c) begin
                aborted_q <= 1'b1;
            end
            if (state_q == ST_HOLD && cnt_q == '0) begin
                timeout_q <= aborted_q;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign to_hit_c    = 1'b0;
    assign aborted_c   = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // Main sequencer: state, phase counter and all registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ctrl_clear_q  <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            addr_q        <= '0;
            dout_q        <= '0;
            oe_q          <= 1'b0;
            ior_n_q       <= 1'b1;
            iow_n_q       <= 1'b1;
        end else begin
            done_q       <= 1'b0;
            ctrl_clear_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q       <= ST_SETUP;
                        cnt_q         <= CNT_W'(SETUP_CYCLES - 1);
                        write_q       <= bus.cmd_write;
                        addr_q        <= bus.cmd_addr;
                        oe_q          <= bus.cmd_write;
                        busy_q        <= 1'b1;
                        rdata_valid_q <= 1'b0;
                        if (bus.cmd_write) begin
                            dout_q <= bus.cmd_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= CNT_W'(STROBE_CYCLES - 1);
                        ior_n_q <= write_q;
                        iow_n_q <= !write_q;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WAIT_RDY;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_WAIT_RDY: begin
                    // Ready wins over a coincident timeout so real data is never discarded.
                    if (sync2_q || to_hit_c) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                        ior_n_q <= 1'b1;
                        iow_n_q <= 1'b1;
                        if (sync2_q && !write_q) begin
                            rdata_q <= bus.isa_data_in;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q       <= ST_DONE;
                        done_q        <= 1'b1;
                        ctrl_clear_q  <= 1'b1;
                        oe_q          <= 1'b0;
                        rdata_valid_q <= !write_q && !aborted_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    oe_q    <= 1'b0;
                    ior_n_q <= 1'b1;
                    iow_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.ctrl_clear   = ctrl_clear_q;
    assign bus.rdata        = rdata_q;
    assign bus.rdata_valid  = rdata_valid_q;
    assign bus.isa_addr     = addr_q;
    assign bus.isa_data_out = dout_q;
    assign bus.isa_data_oe  = oe_q;
    assign bus.isa_ior_n    = ior_n_q;
    assign bus.isa_iow_n    = iow_n_q;
endmodule

// File: tb/tb_isa_cycle_sequencer.sv
// Self-checking bench for isa_cycle_sequencer: directed scenarios plus randomized commands
// checked against a clock-count model of the cycle (setup, strobe, synced ready wait, hold).
module tb_isa_cycle_sequencer;
    localparam int S      = 4;
    localparam int ST     = 16;
    localparam int H      = 4;
    localparam int T      = 8;
    localparam int BUDGET = 300;
`ifdef ISA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    isa_cycle_sequencer_if bus();

    isa_cycle_sequencer #(
        .SETUP_CYCLES  (S),
        .STROBE_CYCLES (ST),
        .HOLD_CYCLES   (H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int o_done_clk, o_done_cnt, o_busy_last, o_lo_first, o_lo_cnt, o_wrong_lo;
    int o_both_lo, o_lo_idle, o_addr_bad, o_oe_bad, o_sd_bad, o_cc_bad, o_to_cnt, o_rdv_bad;
    logic [15:0] o_rdata, o_idle_addr;
    logic        o_rdv, o_idle_oe, o_idle_busy;
    logic [15:0] exp_rdata = 16'h0000;
    int          rdy_a = 0;
    int          rdy_b = 0;

    // IOCHRDY driven in clock n (clock 1 = first clock after start is sampled).
    function automatic bit rdy_at(input int n);
        return !(n >= rdy_a && n < rdy_b);
    endfunction

    // WAIT_RDY residency: ends at the first wait clock whose synced ready (pin value two clocks earlier) is 1.
    function automatic void model(output int w, output bit to);
        int n0;
        n0 = S + ST + 1;
        w  = -1;
        to = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            if (rdy_at(n0 + k - 3)) begin
                w = k;
                return;
            end
            if (TO_EN && k == T) begin
                w  = k;
                to = 1'b1;
                return;
            end
        end
    endfunction

    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] din, input bit spam, input int max_clk);
        bit seen_done;
        o_done_clk = -1; o_done_cnt = 0; o_busy_last = 0; o_lo_first = -1; o_lo_cnt = 0;
        o_wrong_lo = 0; o_both_lo = 0; o_lo_idle = 0; o_addr_bad = 0; o_oe_bad = 0;
        o_sd_bad = 0; o_cc_bad = 0; o_to_cnt = 0; o_rdv_bad = 0;
        seen_done = 1'b0;
        @(negedge clk);
        bus.cmd_write   = wr;
        bus.cmd_addr    = addr;
        bus.cmd_wdata   = wdata;
        bus.isa_data_in = din;
        bus.start       = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= max_clk; n++) begin
            logic lo_act, lo_oth;
            #1;
            bus.start       = spam && !seen_done;
            bus.cmd_write   = 1'($urandom_range(0, 1));
            bus.cmd_addr    = 16'($urandom);
            bus.cmd_wdata   = 16'($urandom);
            bus.isa_iochrdy = rdy_at(n);
            @(negedge clk);
            lo_act = wr ? !bus.isa_iow_n : !bus.isa_ior_n;
            lo_oth = wr ? !bus.isa_ior_n : !bus.isa_iow_n;
            if (lo_act) begin
                o_lo_cnt++;
                if (o_lo_first < 0) o_lo_first = n;
            end
            if (lo_oth) o_wrong_lo++;
            if (!bus.isa_ior_n && !bus.isa_iow_n) o_both_lo++;
            if ((lo_act || lo_oth) && !bus.busy) o_lo_idle++;
            if (bus.busy) o_busy_last = n;
            if (bus.ctrl_clear !== bus.done) o_cc_bad++;
            if (bus.timeout) o_to_cnt++;
            if (bus.timeout && !bus.done) o_cc_bad++;
            if (bus.done) begin
                o_done_cnt++;
                if (!seen_done) o_done_clk = n;
                seen_done = 1'b1;
                if (bus.isa_data_oe) o_oe_bad++;
            end else if (bus.busy) begin
                if (bus.isa_addr !== addr) o_addr_bad++;
                if (bus.isa_data_oe !== wr) o_oe_bad++;
                if (wr && bus.isa_data_out !== wdata) o_sd_bad++;
                if (bus.rdata_valid) o_rdv_bad++;
            end
            if (seen_done && n >= o_done_clk + 3) break;
            @(posedge clk);
        end
        o_idle_addr = bus.isa_addr;
        o_idle_oe   = bus.isa_data_oe;
        o_idle_busy = bus.busy;
        o_rdata     = bus.rdata;
        o_rdv       = bus.rdata_valid;
        bus.start       = 1'b0;
        bus.isa_iochrdy = 1'b1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0; bus.cmd_wdata = 16'h0;
        bus.isa_data_in = 16'hA5A5; bus.isa_iochrdy = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", bus.done); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b exp=0", bus.timeout); end
        total++; if (bus.ctrl_clear !== 1'b0) begin bad++; $display("FAIL rst_ctrl_clear got=%0b exp=0", bus.ctrl_clear); end
        total++; if (bus.rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0000", bus.rdata); end
        total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL rst_rdata_valid got=%0b exp=0", bus.rdata_valid); end
        total++; if (bus.isa_addr !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0000", bus.isa_addr); end
        total++; if (bus.isa_data_out !== 16'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=0000", bus.isa_data_out); end
        total++; if (bus.isa_data_oe !== 1'b0) begin bad++; $display("FAIL rst_oe got=%0b exp=0", bus.isa_data_oe); end
        total++; if (bus.isa_ior_n !== 1'b1) begin bad++; $display("FAIL rst_ior_n got=%0b exp=1", bus.isa_ior_n); end
        total++; if (bus.isa_iow_n !== 1'b1) begin bad++; $display("FAIL rst_iow_n got=%0b exp=1", bus.isa_iow_n); end
        reset = 1'b0;
        exp_rdata = 16'h0;
        repeat (2) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", bus.busy); end
    endtask

    task automatic test_write();
        int w; bit to; int exp_done;
        rdy_a = 0; rdy_b = 0;
        model(w, to);
        exp_done = S + ST + w + H + 1;
        run_txn(1'b1, 16'h0220, 16'h1234, 16'h0000, 1'b0, BUDGET);
        total++; if (o_done_clk !== exp_done) begin bad++; $display("FAIL wr_done_clk got=%0d exp=%0d", o_done_clk, exp_done); end
        total++; if (o_done_cnt !== 1) begin bad++; $display("FAIL wr_done_cnt got=%0d exp=1", o_done_cnt); end
        total++; if (o_lo_cnt !== ST + w) begin bad++; $display("FAIL wr_iow_len got=%0d exp=%0d", o_lo_cnt, ST + w); end
        total++; if (o_lo_first !== S + 1) begin bad++; $display("FAIL wr_iow_first got=%0d exp=%0d", o_lo_first, S + 1); end
        total++; if (o_wrong_lo !== 0) begin bad++; $display("FAIL wr_ior_low got=%0d exp=0", o_wrong_lo); end
        total++; if (o_addr_bad + o_sd_bad + o_oe_bad !== 0) begin bad++; $display("FAIL wr_bus_drive got=%0d/%0d/%0d exp=0/0/0", o_addr_bad, o_sd_bad, o_oe_bad); end
        total++; if (o_busy_last !== exp_done) begin bad++; $display("FAIL wr_busy_last got=%0d exp=%0d", o_busy_last, exp_done); end
        total++; if (o_idle_addr !== 16'h0220 || o_idle_oe !== 1'b0) begin bad++; $display("FAIL wr_idle_hold got=%h/%0b exp=0220/0", o_idle_addr, o_idle_oe); end
        total++; if (o_rdv !== 1'b0) begin bad++; $display("FAIL wr_rdata_valid got=%0b exp=0", o_rdv); end
    endtask

    task automatic test_read_wait();
        int w; bit to; int exp_done;
        rdy_a = S + ST - 3; rdy_b = rdy_a + 10;
        model(w, to);
        exp_done = S + ST + w + H + 1;
        run_txn(1'b0, 16'h0388, 16'h0000, 16'hBEEF, 1'b0, BUDGET);
        if (!to) exp_rdata = 16'hBEEF;
        total++; if (o_done_clk !== exp_done) begin bad++; $display("FAIL rd_done_clk got=%0d exp=%0d", o_done_clk, exp_done); end
        total++; if (o_lo_cnt !== ST + w) begin bad++; $display("FAIL rd_ior_len got=%0d exp=%0d", o_lo_cnt, ST + w); end
        total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL rd_rdata got=%h exp=%h", o_rdata, exp_rdata); end
        total++; if (o_rdv !== !to) begin bad++; $display("FAIL rd_rdata_valid got=%0b exp=%0b", o_rdv, !to); end
        total++; if (o_cc_bad !== 0) begin bad++; $display("FAIL rd_ctrl_clear got=%0d exp=0", o_cc_bad); end
        total++; if (o_wrong_lo + o_both_lo + o_rdv_bad !== 0) begin bad++; $display("FAIL rd_protocol got=%0d/%0d/%0d exp=0/0/0", o_wrong_lo, o_both_lo, o_rdv_bad); end
    endtask

    task automatic test_back_to_back();
        int w; bit to; int exp_done;
        rdy_a = 0; rdy_b = 0;
        model(w, to);
        exp_done = S + ST + w + H + 1;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] a, d, din;
            bit wr;
            a = 16'($urandom); d = 16'($urandom); din = 16'($urandom);
            wr = (i == 0);
            run_txn(wr, a, d, din, 1'b1, BUDGET);
            if (!wr) exp_rdata = din;
            total++; if (o_done_cnt !== 1) begin bad++; $display("FAIL b2b_done_cnt[%0d] got=%0d exp=1", i, o_done_cnt); end
            total++; if (o_done_clk !== exp_done) begin bad++; $display("FAIL b2b_done_clk[%0d] got=%0d exp=%0d", i, o_done_clk, exp_done); end
            total++; if (o_addr_bad + o_sd_bad + o_oe_bad !== 0) begin bad++; $display("FAIL b2b_latched[%0d] got=%0d/%0d/%0d exp=0/0/0", i, o_addr_bad, o_sd_bad, o_oe_bad); end
            total++; if (o_lo_cnt !== ST + w) begin bad++; $display("FAIL b2b_strobe_len[%0d] got=%0d exp=%0d", i, o_lo_cnt, ST + w); end
            total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, o_rdata, exp_rdata); end
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        @(negedge clk);
        bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0300; bus.isa_data_in = 16'h5A5A; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (S + 4) @(posedge clk);
        @(negedge clk);
        total++; if (bus.isa_ior_n !== 1'b0) begin bad++; $display("FAIL rmid_in_strobe got=%0b exp=0", bus.isa_ior_n); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata = 16'h0;
        @(negedge clk);
        total++; if (bus.isa_ior_n !== 1'b1 || bus.isa_iow_n !== 1'b1) begin bad++; $display("FAIL rmid_strobes got=%0b%0b exp=11", bus.isa_ior_n, bus.isa_iow_n); end
        total++; if (bus.isa_data_oe !== 1'b0) begin bad++; $display("FAIL rmid_oe got=%0b exp=0", bus.isa_data_oe); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", bus.busy); end
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.ctrl_clear || bus.timeout) done_seen++;
            @(negedge clk);
        end
        total++; if (done_seen !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d exp=0", done_seen); end
        rdy_a = 0; rdy_b = 0;
        run_txn(1'b0, 16'h0301, 16'h0000, 16'hC0DE, 1'b0, BUDGET);
        exp_rdata = 16'hC0DE;
        total++; if (o_done_clk !== S + ST + H + 2) begin bad++; $display("FAIL rmid_after_done got=%0d exp=%0d", o_done_clk, S + ST + H + 2); end
        total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL rmid_after_rdata got=%h exp=%h", o_rdata, exp_rdata); end
    endtask

    task automatic test_timeout();
        int w; bit to;
        rdy_a = 1; rdy_b = 1000000;
        model(w, to);
`ifdef ISA_TIMEOUT_EN
        run_txn(1'b0, 16'h0388, 16'h0000, 16'h7777, 1'b0, BUDGET);
        total++; if (o_done_clk !== S + ST + w + H + 1) begin bad++; $display("FAIL to_done_clk got=%0d exp=%0d", o_done_clk, S + ST + w + H + 1); end
        total++; if (o_to_cnt !== 1) begin bad++; $display("FAIL to_pulse_cnt got=%0d exp=1", o_to_cnt); end
        total++; if (o_cc_bad !== 0) begin bad++; $display("FAIL to_with_done got=%0d exp=0", o_cc_bad); end
        total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL to_rdata got=%h exp=%h", o_rdata, exp_rdata); end
        total++; if (o_rdv !== 1'b0) begin bad++; $display("FAIL to_rdata_valid got=%0b exp=0", o_rdv); end
        total++; if (o_lo_cnt !== ST + T) begin bad++; $display("FAIL to_strobe_len got=%0d exp=%0d", o_lo_cnt, ST + T); end
`else
        run_txn(1'b0, 16'h0388, 16'h0000, 16'h7777, 1'b0, 120);
        total++; if (o_done_cnt !== 0) begin bad++; $display("FAIL stuck_done_cnt got=%0d exp=0", o_done_cnt); end
        total++; if (o_idle_busy !== 1'b1) begin bad++; $display("FAIL stuck_busy got=%0b exp=1", o_idle_busy); end
        total++; if (o_to_cnt !== 0) begin bad++; $display("FAIL stuck_timeout got=%0d exp=0", o_to_cnt); end
        total++; if (o_lo_cnt !== 120 - S) begin bad++; $display("FAIL stuck_strobe_len got=%0d exp=%0d", o_lo_cnt, 120 - S); end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rdata = 16'h0;
`endif
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int w; bit to; int exp_done; bit wr; bit spam;
            logic [15:0] a, d, din;
            wr = 1'($urandom_range(0, 1));
            spam = ($urandom_range(0, 3) == 0);
            a = 16'($urandom); d = 16'($urandom); din = 16'($urandom);
            rdy_a = $urandom_range(1, 40);
            rdy_b = rdy_a + $urandom_range(0, 20);
            model(w, to);
            exp_done = S + ST + w + H + 1;
            run_txn(wr, a, d, din, spam, BUDGET);
            if (!wr && !to) exp_rdata = din;
            total++; if (o_done_clk !== exp_done) begin bad++; $display("FAIL rnd_done_clk[%0d] got=%0d exp=%0d", it, o_done_clk, exp_done); end
            total++; if (o_lo_cnt !== ST + w || o_lo_first !== S + 1) begin bad++; $display("FAIL rnd_strobe[%0d] got=%0d@%0d exp=%0d@%0d", it, o_lo_cnt, o_lo_first, ST + w, S + 1); end
            total++; if (o_done_cnt !== 1) begin bad++; $display("FAIL rnd_done_cnt[%0d] got=%0d exp=1", it, o_done_cnt); end
            total++; if (o_to_cnt !== int'(to)) begin bad++; $display("FAIL rnd_timeout[%0d] got=%0d exp=%0d", it, o_to_cnt, to); end
            total++; if (o_rdata !== exp_rdata) begin bad++; $display("FAIL rnd_rdata[%0d] got=%h exp=%h", it, o_rdata, exp_rdata); end
            total++; if (o_rdv !== (!wr && !to)) begin bad++; $display("FAIL rnd_rdata_valid[%0d] got=%0b exp=%0b", it, o_rdv, !wr && !to); end
            total++; if (o_busy_last !== exp_done) begin bad++; $display("FAIL rnd_busy_last[%0d] got=%0d exp=%0d", it, o_busy_last, exp_done); end
            total++;
            if (o_addr_bad + o_sd_bad + o_oe_bad + o_wrong_lo + o_both_lo + o_lo_idle + o_cc_bad + o_rdv_bad !== 0) begin
                bad++;
                $display("FAIL rnd_protocol[%0d] got=%0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d exp=all 0", it,
                         o_addr_bad, o_sd_bad, o_oe_bad, o_wrong_lo, o_both_lo, o_lo_idle, o_cc_bad, o_rdv_bad);
            end
            total++; if (o_idle_addr !== a || o_idle_oe !== 1'b0) begin bad++; $display("FAIL rnd_idle_hold[%0d] got=%h/%0b exp=%h/0", it, o_idle_addr, o_idle_oe, a); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
